// File: rtl/img_ram_writer.sv
// ---------------------------------------------------------------------------
// img_ram_writer
//
// Loads a source image into the bilinear scaler's source-frame RAM. A
// raster-order pixel stream (valid/ready, x fastest) is written so that pixel
// (x,y) lands at address y*src_width + x, which is the layout the
// four-neighbour read side expects. busy/done let the scaler wait until the
// whole frame is resident before it starts reading.
//
// Optional feature (compile-time macro IMG_WR_CKSUM_EN):
//   Adds a 16-bit running sum of every accepted pixel on output cksum. It is
//   cleared when a frame starts and is final by the time done pulses.
//
// Ports
//   clk         in   1       system clock, rising edge
//   rst         in   1       synchronous active-high reset
//   start       in   1       begin a frame load (only looked at in IDLE)
//   src_width   in   DIM_W   frame width, latched when a frame starts
//   src_height  in   DIM_W   frame height, latched when a frame starts
//   pix_valid   in   1       pix_data carries a pixel
//   pix_data    in   DATA_W  pixel value, raster order
//   pix_ready   out  1       a pixel is accepted this cycle if pix_valid
//   wr_addr     out  ADDR_W  RAM write address
//   wr_data     out  DATA_W  RAM write data
//   wr_en       out  1       RAM write enable
//   busy        out  1       frame load in progress
//   done        out  1       one-cycle pulse after the last pixel is written
//   cksum       out  16      pixel sum (only with IMG_WR_CKSUM_EN)
// ---------------------------------------------------------------------------
module img_ram_writer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  src_width,
    input  logic [DIM_W-1:0]  src_height,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
`ifdef IMG_WR_CKSUM_EN
    output logic [15:0]       cksum,
`endif
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FIN
    } state_t;

    state_t              r_state;
    logic [DIM_W-1:0]    r_width;
    logic [DIM_W-1:0]    r_height;
    logic [DIM_W-1:0]    r_x;
    logic [DIM_W-1:0]    r_y;
    logic [ADDR_W-1:0]   r_addr_cnt;
    logic                r_pix_ready;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_en;
    logic                r_busy;
    logic                r_done;
`ifdef IMG_WR_CKSUM_EN
    logic [15:0]         r_cksum;
`endif

    // pix_ready is only ever high in LOAD, so accept needs no state qualifier.
    logic w_accept;
    logic w_x_last;
    logic w_last_pix;
    logic w_dims_ok;

    assign w_accept   = pix_valid & r_pix_ready;
    assign w_x_last   = (r_x == r_width  - DIM_W'(1));
    assign w_last_pix = w_x_last & (r_y == r_height - DIM_W'(1));
    assign w_dims_ok  = (src_width != '0) && (src_height != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_addr_cnt  <= '0;
            r_pix_ready <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef IMG_WR_CKSUM_EN
            r_cksum     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge values of the counters it is updating.
            // wr_en and done are pulses: default low, raised only where needed.
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_dims_ok) begin
                            r_width     <= src_width;
                            r_height    <= src_height;
                            r_x         <= '0;
                            r_y         <= '0;
                            r_addr_cnt  <= '0;
                            r_busy      <= 1'b1;
                            r_pix_ready <= 1'b1;
                            r_state     <= S_LOAD;
`ifdef IMG_WR_CKSUM_EN
                            r_cksum     <= '0;
`endif
                        end else begin
                            // Empty frame: nothing to write, report completion.
                            r_done <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (w_accept) begin
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= r_addr_cnt;
                        r_wr_data  <= pix_data;
                        // Running address equals y*W+x without a multiplier.
                        r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
                        if (w_x_last) begin
                            r_x <= '0;
                            r_y <= r_y + DIM_W'(1);
                        end else begin
                            r_x <= r_x + DIM_W'(1);
                        end
`ifdef IMG_WR_CKSUM_EN
                        r_cksum    <= r_cksum + 16'(pix_data);
`endif
                        if (w_last_pix) begin
                            r_pix_ready <= 1'b0;
                            r_state     <= S_FIN;
                        end
                    end
                end

                // FIN overlaps the final write; done follows one cycle later.
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pix_ready = r_pix_ready;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign wr_en     = r_wr_en;
    assign busy      = r_busy;
    assign done      = r_done;
`ifdef IMG_WR_CKSUM_EN
    assign cksum     = r_cksum;
`endif

endmodule

// File: tb/tb_img_ram_writer.sv
// ---------------------------------------------------------------------------
// tb_img_ram_writer
//
// Scoreboard bench for img_ram_writer. The driver issues frames and, for each
// pixel handed over, queues the RAM write it must cause (address from the
// pixel's x/y position, cycle it must appear on). A monitor process pops the
// queue on every clock and compares wr_en/wr_addr/wr_data/done/busy.
// Define IMG_WR_CKSUM_EN to also check the pixel checksum at done.
// ---------------------------------------------------------------------------
module tb_img_ram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  src_width;
    logic [7:0]  src_height;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;
`ifdef IMG_WR_CKSUM_EN
    logic [15:0] cksum;
`endif

    img_ram_writer #(.ADDR_W(16), .DATA_W(8), .DIM_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_width  (src_width),
        .src_height (src_height),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .busy       (busy),
`ifdef IMG_WR_CKSUM_EN
        .cksum      (cksum),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        bit          chk_cks;
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] cks;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, got, want, edge_cnt);
        end
    endtask

    // Monitor: one step per rising edge, sampled 1 time unit later.
    task automatic mon_step();
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
            e = exp_q.pop_front();
            check(e.is_done ? "missed_done" : "missed_write", edge_cnt, e.cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
            e = exp_q.pop_front();
            if (e.is_done) begin
                check("done", done, 1);
                check("busy_at_done", busy, 0);
                check("wr_en_at_done", wr_en, 0);
`ifdef IMG_WR_CKSUM_EN
                if (e.chk_cks) check("cksum_at_done", cksum, e.cks);
`endif
            end else begin
                check("wr_en", wr_en, 1);
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
        end else begin
            check("quiet_wr_en_done", {wr_en, done}, 2'b00);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            mon_step();
        end
    end

    function automatic logic [7:0] data_for(input int pat, input int k);
        logic [7:0] tbl [4];
        tbl = '{8'hFF, 8'hFF, 8'h01, 8'h02};
        case (pat)
            0:       return 8'(k);
            2:       return tbl[k % 4];
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // mode: 0 valid always, 1 toggling 1,0,..., 2 random.
    // abort_at >= 0 resets the DUT once that many pixels have been accepted.
    task automatic run_frame(input int w, input int h, input int mode, input int pat,
                             input bit mid_start, input int abort_at);
        exp_t        e;
        int          k;
        int          n;
        int          last_edge;
        logic [15:0] sum;
        logic [7:0]  d;
        bit          v;

        @(negedge clk);
        start      = 1'b1;
        src_width  = 8'(w);
        src_height = 8'(h);
        if (w == 0 || h == 0) begin
            e = '{is_done: 1'b1, chk_cks: 1'b0, cyc: edge_cnt + 1, addr: '0, data: '0, cks: '0};
            exp_q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            check("busy_zero_dim", busy, 0);
            check("ready_zero_dim", pix_ready, 0);
            repeat (3) @(negedge clk);
            return;
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ready_after_start", pix_ready, 1);

        k = 0;
        n = 0;
        sum = '0;
        last_edge = edge_cnt;
        while (k < w * h) begin
            if (abort_at >= 0 && k == abort_at) begin
                pix_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("wr_en_after_rst", wr_en, 0);
                check("busy_after_rst", busy, 0);
                check("ready_after_rst", pix_ready, 0);
                repeat (3) @(negedge clk);
                return;
            end
            if (mid_start && k == 3) begin
                start      = 1'b1;
                src_width  = 8'(w + 1);
                src_height = 8'(h + 2);
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (n % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = data_for(pat, k);
            pix_valid = v;
            pix_data  = v ? d : 8'($urandom);
            if (v && pix_ready) begin
                e = '{is_done: 1'b0, chk_cks: 1'b0, cyc: edge_cnt + 1,
                      addr: 16'((k / w) * w + (k % w)), data: d, cks: '0};
                exp_q.push_back(e);
                sum = sum + 16'(d);
                last_edge = edge_cnt + 1;
                k++;
            end
            n++;
            if (n > 4 * w * h + 50) begin
                check("frame_timeout", k, w * h);
                break;
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        e = '{is_done: 1'b1, chk_cks: 1'b1, cyc: last_edge + 1, addr: '0, data: '0, cks: sum};
        exp_q.push_back(e);
        check("ready_after_last", pix_ready, 0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        src_width  = '0;
        src_height = '0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        repeat (3) @(negedge clk);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef IMG_WR_CKSUM_EN
        check("rst_cksum", cksum, 0);
`endif
        rst = 1'b0;

        // pix_valid while idle must not write anything.
        repeat (4) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = 8'($urandom);
            check("idle_ready", pix_ready, 0);
        end
        @(negedge clk);
        pix_valid = 1'b0;

        run_frame(4, 3, 0, 0, 1'b0, -1);     // back-to-back, data == addr
        run_frame(4, 3, 1, 0, 1'b0, -1);     // toggling valid
        run_frame(0, 5, 0, 1, 1'b0, -1);     // empty frame
        run_frame(5, 0, 0, 1, 1'b0, -1);
        run_frame(4, 3, 2, 1, 1'b1, -1);     // start mid-frame ignored
        run_frame(4, 3, 0, 1, 1'b0, 5);      // reset after 5 pixels
        run_frame(2, 2, 0, 0, 1'b0, -1);     // restarts at address 0
        run_frame(2, 2, 0, 2, 1'b0, -1);     // checksum 0x0201
        run_frame(2, 2, 2, 3, 1'b0, -1);     // checksum 0x03FC
        run_frame(1, 5, 2, 1, 1'b0, -1);     // W=1
        run_frame(6, 1, 0, 1, 1'b0, -1);     // H=1
        run_frame(255, 4, 2, 1, 1'b0, -1);   // widest line
        run_frame(3, 255, 0, 1, 1'b0, -1);   // tallest frame
        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(1, 9), $urandom_range(1, 9), 2, 1, 1'b0, -1);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
